// File: rtl/lif_mon_pkg.sv
// Shared types, width constants and saturation helper for the LIF spike monitor.
package lif_mon_pkg;

  localparam int unsigned TS_W_DEF = 16;
  localparam int unsigned VWORD_W  = 16;

  typedef struct packed {
`ifdef LIF_MON_ISI_EN
    logic [TS_W_DEF-1:0] isi;
`endif
    logic [TS_W_DEF-1:0] ts;
    logic [VWORD_W-1:0]  v;
  } lif_event_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/lif_event_fifo.sv
// Generic show-ahead synchronous FIFO; dout holds the last popped word while empty.
module lif_event_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] hold;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot being written, so push while full is accepted alongside it.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? hold : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/lif_spike_monitor.sv
// Timestamps LIF neuron spikes, queues {ts, pre-spike membrane} events and counts windowed spike rate.
// Optional per-event inter-spike interval output enabled by defining LIF_MON_ISI_EN.
module lif_spike_monitor
  import lif_mon_pkg::*;
#(
  parameter int unsigned TS_W    = TS_W_DEF,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned WIN_LEN = 256,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [15:0]        v_in,
  input  logic               spike_in,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [TS_W-1:0]    ev_ts,
  output logic [15:0]        ev_v,
  output logic [CNT_W-1:0]   rate_count,
  output logic               rate_valid,
  output logic               overflow,
  output logic [7:0]         drop_cnt
`ifdef LIF_MON_ISI_EN
  ,output logic [TS_W-1:0]   ev_isi
`endif
);

`ifdef LIF_MON_ISI_EN
  localparam int unsigned ENT_W = 2 * TS_W + VWORD_W;
`else
  localparam int unsigned ENT_W = TS_W + VWORD_W;
`endif
  localparam int unsigned WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]    ts;
  logic [VWORD_W-1:0] v_prev;
  logic [WIN_W-1:0]   win;
  logic [CNT_W-1:0]   acc, acc_next;
  logic               cap, full, empty;
  logic [ENT_W-1:0]   din, dout;

  assign cap = run && spike_in;

  always_comb begin
    acc_next = acc;
    if (cap) acc_next = CNT_W'(sat_inc(32'(acc), 32'(CNT_MAX)));
  end

`ifdef LIF_MON_ISI_EN
  localparam logic [TS_W-1:0] TS_MAX = '1;
  logic [TS_W-1:0] isi_cnt;
  logic            isi_seen;

  // isi_cnt equals cycles elapsed since the last captured spike, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isi_cnt  <= '0;
      isi_seen <= 1'b0;
    end else if (!run) begin
      isi_cnt  <= '0;
      isi_seen <= 1'b0;
    end else if (cap) begin
      isi_cnt  <= TS_W'(1);
      isi_seen <= 1'b1;
    end else begin
      isi_cnt  <= TS_W'(sat_inc(32'(isi_cnt), 32'(TS_MAX)));
    end
  end

  assign din    = {(isi_seen ? isi_cnt : '0), ts, v_prev};
  assign ev_isi = dout[ENT_W-1 -: TS_W];
`else
  assign din = {ts, v_prev};
`endif

  assign ev_ts    = dout[VWORD_W +: TS_W];
  assign ev_v     = dout[VWORD_W-1:0];
  assign ev_valid = !empty;

  lif_event_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cap),
    .pop  (ev_ready),
    .din  (din),
    .full (full),
    .empty(empty),
    .dout (dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts     <= '0;
      v_prev <= '0;
    end else if (run) begin
      ts     <= ts + 1'b1;
      v_prev <= v_in;
    end else begin
      ts     <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (cap && full && !ev_ready) begin
      overflow <= 1'b1;
      drop_cnt <= 8'(sat_inc(32'(drop_cnt), 32'd255));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win        <= '0;
      acc        <= '0;
      rate_count <= '0;
      rate_valid <= 1'b0;
    end else if (!run) begin
      win        <= '0;
      acc        <= '0;
      rate_valid <= 1'b0;
    end else if (win == WIN_W'(WIN_LEN - 1)) begin
      win        <= '0;
      acc        <= '0;
      rate_count <= acc_next;
      rate_valid <= 1'b1;
    end else begin
      win        <= win + 1'b1;
      acc        <= acc_next;
      rate_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Randomized self-checking bench for lif_spike_monitor against an event-queue reference model.
module tb_lif_spike_monitor;

  localparam int TS_W    = 8;
  localparam int DEPTH   = 8;
  localparam int WIN_LEN = 4;
  localparam int CNT_W   = 2;
  localparam int TS_MOD  = 1 << TS_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              spike_in = 1'b0;
  logic              ev_ready = 1'b0;
  logic [15:0]       v_in = '0;
  logic              ev_valid, rate_valid, overflow;
  logic [TS_W-1:0]   ev_ts;
  logic [15:0]       ev_v;
  logic [CNT_W-1:0]  rate_count;
  logic [7:0]        drop_cnt;
`ifdef LIF_MON_ISI_EN
  logic [TS_W-1:0]   ev_isi;
`endif

  lif_spike_monitor #(
    .TS_W   (TS_W),
    .DEPTH  (DEPTH),
    .WIN_LEN(WIN_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .v_in      (v_in),
    .spike_in  (spike_in),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_ts     (ev_ts),
    .ev_v      (ev_v),
    .rate_count(rate_count),
    .rate_valid(rate_valid),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
`ifdef LIF_MON_ISI_EN
    ,.ev_isi   (ev_isi)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int ts; int v; int isi;} ev_t;
  ev_t q[$];
  ev_t hold;
  int ts_m, vprev_m, win_m, acc_m, rc_m, rv_m, ovf_m, drop_m;
  int run_idx, last_idx, have_prev;
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hold = '{0, 0, 0};
    ts_m = 0; vprev_m = 0; win_m = 0; acc_m = 0; rc_m = 0; rv_m = 0;
    ovf_m = 0; drop_m = 0; run_idx = 0; last_idx = 0; have_prev = 0;
  endtask

  task automatic check_all();
    ev_t head;
    head = (q.size() > 0) ? q[0] : hold;
    chk("ev_valid", 32'(ev_valid), 32'(q.size() > 0));
    chk("ev_ts", 32'(ev_ts), head.ts);
    chk("ev_v", 32'(ev_v), head.v);
`ifdef LIF_MON_ISI_EN
    chk("ev_isi", 32'(ev_isi), head.isi);
`endif
    chk("rate_count", 32'(rate_count), rc_m);
    chk("rate_valid", 32'(rate_valid), rv_m);
    chk("overflow", 32'(overflow), ovf_m);
    chk("drop_cnt", 32'(drop_cnt), drop_m);
  endtask

  // Advance the reference model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit cap;
    ev_t e;
    cap = run && spike_in;
    if (q.size() > 0 && ev_ready) hold = q.pop_front();
    if (cap) begin
      e.ts  = ts_m;
      e.v   = vprev_m;
      e.isi = have_prev ? ((run_idx - last_idx > TS_MOD - 1) ? TS_MOD - 1 : run_idx - last_idx) : 0;
      if (q.size() < DEPTH) q.push_back(e);
      else begin
        ovf_m  = 1;
        drop_m = (drop_m < 255) ? drop_m + 1 : 255;
      end
    end
    if (run) begin
      if (cap) begin last_idx = run_idx; have_prev = 1; end
      run_idx++;
      if (win_m == WIN_LEN - 1) begin
        rc_m  = (acc_m + int'(cap) > CNT_MAX) ? CNT_MAX : acc_m + int'(cap);
        rv_m  = 1;
        win_m = 0;
        acc_m = 0;
      end else begin
        acc_m = (acc_m + int'(cap) > CNT_MAX) ? CNT_MAX : acc_m + int'(cap);
        rv_m  = 0;
        win_m++;
      end
      ts_m    = (ts_m + 1) % TS_MOD;
      vprev_m = int'(v_in);
    end else begin
      run_idx = 0; have_prev = 0; win_m = 0; acc_m = 0; rv_m = 0; ts_m = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic [15:0] v, input logic rdy);
    run = r; spike_in = s; v_in = v; ev_ready = rdy;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic run_state;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Spike at ts=5 with the previous membrane word 0x2000.
    for (int i = 0; i < 8; i++)
      drive(1'b1, i == 5, (i < 4) ? 16'h1000 : 16'h2000, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b1);

    // Nine spikes into a stalled FIFO, then drain.
    for (int i = 0; i < 11; i++) drive(1'b1, i >= 1 && i <= 9, 16'(i * 2), 1'b0);
    // Full FIFO with a spike coinciding with a pop.
    drive(1'b1, 1'b1, 16'h0ABC, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 16'h0, 1'b1);

    // Window boundaries: spikes at ts=0,2,3 then silence; then run drop mid-window.
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, i == 0 || i == 2 || i == 3, 16'h0100, 1'b0);
    drive(1'b1, 1'b1, 16'h0200, 1'b0);
    drive(1'b1, 1'b1, 16'h0300, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'h0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 16'h0400, 1'b1);

    // Reset with events queued.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16'h1234, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0, 1'b1);

    // Long silence for interval saturation and timestamp wrap.
    drive(1'b1, 1'b1, 16'h5550, 1'b1);
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, 16'(i * 2), 1'b1);
    drive(1'b1, 1'b1, 16'h6660, 1'b1);
    drive(1'b1, 1'b0, 16'h0, 1'b1);

    // Randomized traffic with occasional run toggles.
    run_state = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 4) run_state = ~run_state;
      drive(run_state, $urandom_range(0, 99) < 40, 16'($urandom) & 16'hFFFE,
            $urandom_range(0, 99) < 50);
      if ($urandom_range(0, 999) < 3) do_reset();
    end

    // Drop counter saturation.
    for (int i = 0; i < 280; i++) drive(1'b1, 1'b1, 16'($urandom) & 16'hFFFE, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 16'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lif_spike_monitor.md
Name: lif_spike_monitor

Overview:
- Sits directly downstream of the LIF neuron core and consumes its per-cycle output stream: membrane word and spike flag.
- Timestamps every spike and captures the membrane value from the cycle before the spike; at the spike cycle itself the neuron outputs E_REST.
- Queues these events in a small FIFO for a host-side reader using valid/ready.
- Also produces a windowed spike-rate count.

Parameters:
- TS_W, 16: timestamp counter width (bits).
- DEPTH, 8: event FIFO depth; must be a power of 2, at least 2.
- WIN_LEN, 256: rate window length in clock cycles, at least 1.
- CNT_W, 8: spike-rate counter width (saturating).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  neuron is in its work state (same condition that drives the neuron's IO-enable high).
- v_in  in  16  membrane word = {uo_out, uio_out[7:1], 1'b0}.
- spike_in  in  1  neuron spike flag (uio_out[0]).
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head this cycle.
- ev_ts  out  TS_W  timestamp of the head event.
- ev_v  out  16  pre-spike membrane of the head event.
- rate_count  out  CNT_W  spike count of the last completed window.
- rate_valid  out  1  one-cycle pulse when rate_count updates.
- overflow  out  1  sticky: at least one event was dropped.
- drop_cnt  out  8  dropped-event count, saturates at 255.

Behaviour:
- Reset (async assert, sync-style deassert inside): ev_valid=0, ev_ts=0, ev_v=0, rate_count=0, rate_valid=0, overflow=0, drop_cnt=0. Also clears the timestamp, window counter, spike accumulator, v_prev and the FIFO pointers. Reset mid-operation discards all queued events.
- Timestamp ts:
  - run=0: ts held at 0.
  - run=1: ts increments by 1 every cycle, starting at 0 on the first run cycle.
  - Wraps from 2^TS_W-1 to 0 silently.
- v_prev: register loaded with v_in every run cycle; holds when run=0.
- Event capture: on a cycle with run=1 and spike_in=1, push {ts, v_prev}.
  - ts is the value in that same cycle.
  - v_prev is the v_in of the previous run cycle, or 0 on the first run cycle.
- spike_in while run=0 is ignored.
- FIFO is show-ahead (first-word-fall-through): a push in cycle N makes ev_valid=1 in cycle N+1 if the FIFO was empty.
- Pop occurs when ev_valid && ev_ready.
- ev_ts and ev_v are stable while ev_valid=1 and ev_ready=0.
- Empty: ev_valid=0; ev_ready is ignored; ev_ts and ev_v hold their last values.
- Full, push without pop: event dropped, overflow set, drop_cnt incremented (saturating).
- Full, push with simultaneous pop: both succeed, no drop, occupancy unchanged.
- Empty with a push: no bypass in the same cycle; the event appears next cycle.
- Rate window:
  - win counter runs 0..WIN_LEN-1 while run=1.
  - Accumulator adds 1 for each captured spike, saturating at 2^CNT_W-1.
  - At win==WIN_LEN-1, rate_count takes acc plus this cycle's spike (saturated), rate_valid pulses for 1 cycle, and acc and win reset to 0.
- run falling: win and acc clear to 0 and the partial window is discarded. FIFO contents, rate_count, overflow and drop_cnt are retained.
- overflow and drop_cnt clear only on rst.

Optional Feature:
- Macro: LIF_MON_ISI_EN.
- Defined:
  - Adds output ev_isi[TS_W-1:0], stored per event: cycles since the previous captured spike in this run.
  - Saturates at 2^TS_W-1.
  - The first spike after run rises reports 0.
  - The FIFO entry widens by TS_W.
- Undefined: no ev_isi port, no ISI counter, FIFO entry is TS_W+16 bits.

Decomposition:
- Shared package lif_mon_pkg holds:
  - the event record type (ts, v, optional isi);
  - default width constants TS_W_DEF=16 and VWORD_W=16;
  - the saturation helper function.
- One sub-module: lif_event_fifo, a generic show-ahead synchronous FIFO with WIDTH and DEPTH parameters, push/pop/full/empty. It is instantiated once.
- Timestamp, window and capture logic stay in the top.

Test Plan:
- Reset, run=1, v_in=0x1000, then 0x2000, spike_in=1 at ts=5, ev_ready=1 -> cycle 6 shows ev_valid=1, ev_ts=5, ev_v=0x2000; cycle 7 shows ev_valid=0.
- ev_ready=0, 9 spikes at ts=1..9 (DEPTH=8) -> 8 events kept (ts 1..8), overflow=1, drop_cnt=1; draining returns ts 1..8 in order.
- FIFO full, spike coincident with a pop -> no drop, drop_cnt unchanged, new ts appears last.
- WIN_LEN=4, spikes at ts=0,2,3, then none -> rate_valid pulses at ts=3 with rate_count=3, and at ts=7 with rate_count=0.
- run=0 mid-window with 2 spikes queued -> no rate_valid pulse, events retained. run=1 again -> ts restarts at 0.
- LIF_MON_ISI_EN defined, spikes at ts=10,25 -> ev_isi=0 then 15. rst asserted mid-queue -> ev_valid=0 asynchronously.
